atomic_read_initiator: RTL and testbench

//   Bus-master side of the 64-bit event-counter read protocol. Takes one 64-bit read command from a

---
 rtl/atomic_rd_pkg.sv | 17 +
 rtl/ack_watchdog.sv | 34 +++
 rtl/atomic_read_initiator.sv | 140 ++++++++++++++
 tb/tb_atomic_read_initiator.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atomic_rd_pkg.sv
// Shared types and constants for the 64-bit atomic counter read initiator.
// Holds the FSM state encoding and the bus/result word widths.
package atomic_rd_pkg;

  localparam int ACK_LATENCY = 1;
  localparam int WORD_W      = 32;
  localparam int CNT_W       = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    REQ_HI,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/ack_watchdog.sv
// Ack watchdog: restarts on every bus request and flags expiry after
// ACK_TIMEOUT cycles of waiting. Ports: clk, reset (async low), restart, enable, expire.
module ack_watchdog
  import atomic_rd_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(ACK_TIMEOUT + 1);
  // The counter starts at zero in the nominal ack cycle, so the last
  // waiting cycle is ACK_TIMEOUT-ACK_LATENCY.
  localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - ACK_LATENCY);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = enable && !restart && (cnt_q == LAST);

endmodule

// File: rtl/atomic_read_initiator.sv
// Bus master for 64-bit counter reads: one host command becomes an atomic
// low-word access plus a high-word access, returned as {hi,lo} on rsp_*.
// Ports: clk, reset (async low), cmd_valid_i/cmd_ready_o, rsp_valid_o/
// rsp_ready_i/rsp_data_o/rsp_err_o, req_o/atomic_o/ack_i/count_i.
module atomic_read_initiator
  import atomic_rd_pkg::*;
#(
  parameter bit BACK2BACK   = 1'b1,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [CNT_W-1:0]  rsp_data_o,
  output logic              rsp_err_o,
  output logic              req_o,
  output logic              atomic_o,
  input  logic              ack_i,
  input  logic [WORD_W-1:0] count_i
);

  state_t             state_q, state_d;
  logic [1:0]         ack_cnt_q, ack_cnt_d;
  logic [WORD_W-1:0]  lo_q, lo_d;
  logic [WORD_W-1:0]  hi_q, hi_d;
  logic [CNT_W-1:0]   rsp_data_q;
  logic               rsp_err_q;
  logic               start;
  logic               ack_ok;
  logic               lo_take;
  logic               hi_take;
  logic               done;
  logic               abort;
  logic               load_rsp;
  logic               wd_enable;
  logic               wd_expire;

  // Acks only count while a read has accesses outstanding; anything in
  // IDLE/RESP (stray or post-abort) is dropped.
  assign ack_ok  = ack_i &&
                   ((state_q == REQ_HI) || (state_q == WAIT));
  assign lo_take = ack_ok && (ack_cnt_q == 2'd0);
  assign hi_take = ack_ok && (ack_cnt_q == 2'd1);
  assign done    = hi_take || (ack_cnt_q == 2'd2);

  assign wd_enable = ((state_q == REQ_HI) || (state_q == WAIT))
                     && (ack_cnt_q != 2'd2);

  ack_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .restart (req_o),
    .enable  (wd_enable),
    .expire  (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = REQ_LO;
          start   = 1'b1;
        end
      end
      REQ_LO: begin
        state_d = BACK2BACK ? REQ_HI : WAIT;
      end
      REQ_HI: begin
        state_d = done ? RESP : WAIT;
      end
      WAIT: begin
        if (done) begin
          state_d = RESP;
        end else if (!BACK2BACK && lo_take) begin
          state_d = REQ_HI;
        end else if (wd_expire) begin
          state_d = RESP;
          abort   = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_cnt_d = ack_cnt_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    if (start) begin
      ack_cnt_d = 2'd0;
      lo_d      = '0;
      hi_d      = '0;
    end else if (ack_ok && (ack_cnt_q != 2'd2)) begin
      ack_cnt_d = ack_cnt_q + 2'd1;
      if (lo_take) lo_d = count_i;
      if (hi_take) hi_d = count_i;
    end
  end

  assign load_rsp = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ack_cnt_q  <= 2'd0;
      lo_q       <= '0;
      hi_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      if (load_rsp) begin
        rsp_data_q <= abort ? '0 : {hi_d, lo_d};
        rsp_err_q  <= abort;
      end
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign req_o       = (state_q == REQ_LO) || (state_q == REQ_HI);
  assign atomic_o    = (state_q == REQ_LO);

endmodule

// File: tb/tb_atomic_read_initiator.sv
// Bench for atomic_read_initiator: instance 0 BACK2BACK=1, instance 1
// BACK2BACK=0, each behind a snapshotting counter responder.
module tb_atomic_read_initiator;

  logic        clk;
  logic        reset;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [63:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic        req       [2];
  logic        atomic    [2];
  logic        ack       [2];
  logic [31:0] count     [2];

  logic [63:0] evt       [2];
  logic [31:0] snap_hi   [2];
  logic [63:0] snap_full [2];
  logic        trig      [2];
  logic        drop_hi   [2];
  logic        load      [2];
  logic [63:0] load_val  [2];

  int n_chk;
  int n_pass;

  atomic_read_initiator #(.BACK2BACK(1'b1), .ACK_TIMEOUT(4)) u_b2b (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_data_o(rsp_data[0]), .rsp_err_o(rsp_err[0]),
    .req_o(req[0]), .atomic_o(atomic[0]),
    .ack_i(ack[0]), .count_i(count[0])
  );

  atomic_read_initiator #(.BACK2BACK(1'b0), .ACK_TIMEOUT(4)) u_seq (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_data_o(rsp_data[1]), .rsp_err_o(rsp_err[1]),
    .req_o(req[1]), .atomic_o(atomic[1]),
    .ack_i(ack[1]), .count_i(count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: ack one cycle after req; atomic access snapshots the
  // upper word, the following access returns the snapshot.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load[i]) evt[i] <= load_val[i];
      else if (trig[i]) evt[i] <= evt[i] + 64'd1;
      ack[i]   <= 1'b0;
      count[i] <= 32'h0;
      if (req[i]) begin
        if (atomic[i]) begin
          ack[i]       <= 1'b1;
          count[i]     <= evt[i][31:0];
          snap_hi[i]   <= evt[i][63:32];
          snap_full[i] <= evt[i];
        end else if (!drop_hi[i]) begin
          ack[i]   <= 1'b1;
          count[i] <= snap_hi[i];
        end
      end
    end
  end

  task automatic preload(input int i, input logic [63:0] v);
    @(negedge clk);
    load[i]     = 1'b1;
    load_val[i] = v;
    @(negedge clk);
    load[i] = 1'b0;
  endtask

  task automatic run_trace(input int i,
                           output logic [5:0] rq,
                           output logic [5:0] at,
                           output logic [5:0] vl,
                           output logic [5:0] cr,
                           output logic [63:0] d);
    rq = '0; at = '0; vl = '0; cr = '0; d = '0;
    @(negedge clk);
    cmd_valid[i] = 1'b1;
    rsp_ready[i] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cmd_valid[i] = 1'b0;
      rq[k] = req[i];
      at[k] = atomic[i];
      vl[k] = rsp_valid[i];
      cr[k] = cmd_ready[i];
      if (rsp_valid[i]) d = rsp_data[i];
    end
  endtask

  task automatic do_read(input int i, output logic [63:0] d,
                         output logic e, output bit ok);
    d = '0; e = 1'b0; ok = 1'b0;
    @(negedge clk);
    cmd_valid[i] = 1'b1;
    rsp_ready[i] = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      cmd_valid[i] = 1'b0;
      if (rsp_valid[i]) begin
        ok = 1'b1;
        d  = rsp_data[i];
        e  = rsp_err[i];
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({cmd_ready[i], req[i], atomic[i], rsp_valid[i], rsp_err[i]}
          !== 5'b10000) begin
        $display("FAIL reset_ctl[%0d] got %b want 10000", i,
          {cmd_ready[i], req[i], atomic[i], rsp_valid[i], rsp_err[i]});
      end else n_pass++;
      n_chk++;
      if (rsp_data[i] !== 64'h0) begin
        $display("FAIL reset_data[%0d] got %h want 0", i, rsp_data[i]);
      end else n_pass++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_b2b_timing;
    logic [5:0] rq, at, vl, cr;
    logic [63:0] d;
    preload(0, 64'hCAFE_F00D_0000_0042);
    run_trace(0, rq, at, vl, cr, d);
    n_chk++;
    if (rq !== 6'b000011) $display("FAIL b2b_req got %b want 000011", rq);
    else n_pass++;
    n_chk++;
    if (at !== 6'b000001) $display("FAIL b2b_atomic got %b want 000001", at);
    else n_pass++;
    n_chk++;
    if (vl !== 6'b001000) $display("FAIL b2b_valid got %b want 001000", vl);
    else n_pass++;
    n_chk++;
    if (cr !== 6'b110000) $display("FAIL b2b_ready got %b want 110000", cr);
    else n_pass++;
    n_chk++;
    if (d !== 64'hCAFE_F00D_0000_0042)
      $display("FAIL b2b_data got %h want cafef00d00000042", d);
    else n_pass++;
  endtask

  task automatic test_seq_timing;
    logic [5:0] rq, at, vl, cr;
    logic [63:0] d;
    preload(1, 64'hDEAD_BEEF_0123_4567);
    run_trace(1, rq, at, vl, cr, d);
    n_chk++;
    if (rq !== 6'b000101) $display("FAIL seq_req got %b want 000101", rq);
    else n_pass++;
    n_chk++;
    if (at !== 6'b000001) $display("FAIL seq_atomic got %b want 000001", at);
    else n_pass++;
    n_chk++;
    if (vl !== 6'b010000) $display("FAIL seq_valid got %b want 010000", vl);
    else n_pass++;
    n_chk++;
    if (cr !== 6'b100000) $display("FAIL seq_ready got %b want 100000", cr);
    else n_pass++;
    n_chk++;
    if (d !== 64'hDEAD_BEEF_0123_4567)
      $display("FAIL seq_data got %h want deadbeef01234567", d);
    else n_pass++;
  endtask

  task automatic test_no_tear;
    logic [63:0] d;
    logic e;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      preload(i, 64'h0000_0001_FFFF_FFFE);
      trig[i] = 1'b1;
      do_read(i, d, e, ok);
      trig[i] = 1'b0;
      n_chk++;
      if (!ok || e !== 1'b0 || d !== snap_full[i])
        $display("FAIL tear_snap[%0d] got %h want %h", i, d, snap_full[i]);
      else n_pass++;
      n_chk++;
      if (d < 64'h0000_0001_FFFF_FFFE || d > 64'h0000_0002_0000_0008)
        $display("FAIL tear_range[%0d] got %h want 1fffffffe..200000008",
                 i, d);
      else n_pass++;
    end
  endtask

  task automatic test_timeout;
    int n_req;
    int k_valid;
    logic [63:0] d;
    logic e;
    for (int i = 0; i < 2; i++) begin
      n_req = 0; k_valid = -1; d = '1; e = 1'b0;
      drop_hi[i] = 1'b1;
      @(negedge clk);
      cmd_valid[i] = 1'b1;
      rsp_ready[i] = 1'b0;
      for (int k = 0; k < 20 && k_valid < 0; k++) begin
        @(negedge clk);
        cmd_valid[i] = 1'b0;
        if (req[i]) n_req++;
        if (rsp_valid[i]) begin
          k_valid = k;
          d = rsp_data[i];
          e = rsp_err[i];
        end
      end
      n_chk++;
      if (k_valid !== (i == 0 ? 6 : 7))
        $display("FAIL tmo_cycle[%0d] got %0d want %0d", i, k_valid,
                 (i == 0 ? 6 : 7));
      else n_pass++;
      n_chk++;
      if (e !== 1'b1 || d !== 64'h0)
        $display("FAIL tmo_err[%0d] got err=%b data=%h want err=1 data=0",
                 i, e, d);
      else n_pass++;
      repeat (3) @(negedge clk);
      if (req[i]) n_req++;
      n_chk++;
      if (n_req !== 2)
        $display("FAIL tmo_reqs[%0d] got %0d want 2", i, n_req);
      else n_pass++;
      rsp_ready[i] = 1'b1;
      drop_hi[i]   = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    bit stable;
    logic [63:0] d;
    logic e;
    preload(1, 64'h1234_5678_9ABC_DEF0);
    cmd_valid[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = rsp_valid[1];
    end
    n_chk++;
    if (!ok) $display("FAIL bp_first got no rsp_valid want rsp_valid");
    else n_pass++;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!rsp_valid[1] || rsp_data[1] !== 64'h1234_5678_9ABC_DEF0 ||
          rsp_err[1] !== 1'b0 || cmd_ready[1] !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    n_chk++;
    if (!stable)
      $display("FAIL bp_hold got data=%h ready=%b want 123456789abcdef0 0",
               rsp_data[1], cmd_ready[1]);
    else n_pass++;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({rsp_valid[1], cmd_ready[1]} !== 2'b01)
      $display("FAIL bp_release got %b want 01",
               {rsp_valid[1], cmd_ready[1]});
    else n_pass++;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    n_chk++;
    if ({req[1], atomic[1], cmd_ready[1]} !== 3'b110)
      $display("FAIL bp_accept got %b want 110",
               {req[1], atomic[1], cmd_ready[1]});
    else n_pass++;
    ok = 1'b0; d = '0; e = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin
        ok = 1'b1; d = rsp_data[1]; e = rsp_err[1];
      end
    end
    n_chk++;
    if (!ok || e !== 1'b0 || d !== 64'h1234_5678_9ABC_DEF0)
      $display("FAIL bp_second got %h want 123456789abcdef0", d);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [63:0] d;
    logic e;
    bit ok;
    preload(1, 64'h0000_0000_AAAA_5555);
    @(negedge clk);
    cmd_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({req[1], cmd_ready[1]} !== 2'b00)
      $display("FAIL rst_mid_pre got %b want 00", {req[1], cmd_ready[1]});
    else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({cmd_ready[1], req[1], atomic[1], rsp_valid[1], rsp_err[1]}
        !== 5'b10000 || rsp_data[1] !== 64'h0)
      $display("FAIL rst_mid_async got %b/%h want 10000/0",
        {cmd_ready[1], req[1], atomic[1], rsp_valid[1], rsp_err[1]},
        rsp_data[1]);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    preload(1, 64'h0BAD_F00D_7777_8888);
    do_read(1, d, e, ok);
    n_chk++;
    if (!ok || e !== 1'b0 || d !== 64'h0BAD_F00D_7777_8888)
      $display("FAIL rst_mid_fresh got %h want 0badf00d77778888", d);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
      trig[i]      = 1'b0;
      drop_hi[i]   = 1'b0;
      load[i]      = 1'b0;
      load_val[i]  = 64'h0;
    end
    test_reset;
    test_b2b_timing;
    test_seq_timing;
    test_no_tear;
    test_timeout;
    test_backpressure;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
